// File: rtl/osc_fll_pkg.sv
// Shared types and helpers for the ring-oscillator frequency-locked-loop controller.
package osc_fll_pkg;

  typedef enum logic [2:0] {IDLE, START, MEAS, CALC, UPDATE} fsm_state_e;

  localparam int CODE_W   = 9;
  localparam int CODE_MAX = 287;
  localparam int MSB_UNIT = 32;

  // Thermometer of the msb field: m ones from bit 0, m in 0..8.
  function automatic logic [7:0] code2therm(input logic [3:0] m);
    logic [8:0] t;
    t = (9'd1 << m) - 9'd1;
    return t[7:0];
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/osc_fll_ctrl_sync.sv
// Two-flop synchroniser for the gray-coded oscillator edge count, then gray->binary.
module osc_cnt_sync
  import osc_fll_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             ref_clk,
  input  logic             rstb,
  input  logic [CNT_W-1:0] cnt_gray,
  output logic [CNT_W-1:0] cnt_bin
);

  logic [CNT_W-1:0] meta_reg;
  logic [CNT_W-1:0] sync_reg;

  always_ff @(posedge ref_clk or negedge rstb) begin
    if (!rstb) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= cnt_gray;
      sync_reg <= meta_reg;
    end
  end

  assign cnt_bin = CNT_W'(gray2bin(32'(sync_reg)));

endmodule

// File: rtl/osc_fll_ctrl.sv
// FLL controller: measures oscillator edges per ref_clk window and steps per-stage
// varactor codes round-robin toward the target count; also emits LFSR dither words.
module osc_fll_ctrl
  import osc_fll_pkg::*;
#(
  parameter int NSTG      = 5,
  parameter int CNT_W     = 12,
  parameter int WIN_CYC   = 64,
  parameter int INIT_CODE = 144,
  parameter int COARSE_TH = 8,
  parameter int LOCK_TOL  = 1,
  parameter int LOCK_CNT  = 4
) (
  input  logic                   ref_clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [CNT_W-1:0]       target_cnt,
  input  logic [CNT_W-1:0]       osc_cnt_gray,
  input  logic                   dither_en,
  output logic                   glob_en,
  output logic [NSTG-1:0][7:0]   delay_con_msb,
  output logic [NSTG-1:0][4:0]   delay_con_lsb,
  output logic [NSTG-1:0][3:0]   con_perb,
  output logic                   locked,
  output logic                   sat,
  output logic [CNT_W-1:0]       meas_cnt
);

  localparam int WIN_W = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1;
  localparam int PTR_W = (NSTG > 1) ? $clog2(NSTG) : 1;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [CODE_W-1:0] INIT_C = CODE_W'(INIT_CODE);

  fsm_state_e                    state_reg;
  logic [CNT_W-1:0]              cnt_bin, cnt0_reg, cnt1_reg, meas_diff;
  logic [WIN_W-1:0]              win_cnt_reg;
  logic signed [CNT_W:0]         err_reg;
  logic [NSTG-1:0][CODE_W-1:0]   code_reg, code_next;
  logic [PTR_W-1:0]              ptr_reg, ptr_next;
  logic [LCK_W-1:0]              lock_cnt_reg;
  logic [15:0]                   lfsr_reg;
  logic [NSTG-1:0][3:0]          perb_next;

  logic [CNT_W:0]                abs_err;
  logic                          go_up, in_lock, found, at_lim;
  logic [CODE_W-1:0]             step, cur;
  logic [PTR_W:0]                idx_ext;
  logic [PTR_W-1:0]              idx, sel;

  osc_cnt_sync #(.CNT_W(CNT_W)) u_sync (
    .ref_clk (ref_clk),
    .rstb    (rstb),
    .cnt_gray(osc_cnt_gray),
    .cnt_bin (cnt_bin)
  );

  assign meas_diff = cnt1_reg - cnt0_reg;

  // Dither nibble i is LFSR bits 4i..4i+3 (wrapping past bit 15), rotated left by i.
  for (genvar gi = 0; gi < NSTG; gi++) begin : g_perb
    for (genvar gk = 0; gk < 4; gk++) begin : g_bit
      assign perb_next[gi][gk] = lfsr_reg[(4*gi + ((gk + 4 - (gi % 4)) % 4)) % 16];
    end
  end

  // Step decision and limit-aware stage search, starting at ptr.
  always_comb begin
    abs_err   = err_reg[CNT_W] ? (~err_reg + 1'b1) : err_reg;
    go_up     = !err_reg[CNT_W];
    in_lock   = abs_err <= (CNT_W+1)'(LOCK_TOL);
    step      = (abs_err > (CNT_W+1)'(COARSE_TH)) ? CODE_W'(MSB_UNIT) : CODE_W'(1);
    found     = 1'b0;
    at_lim    = 1'b0;
    sel       = ptr_reg;
    idx_ext   = '0;
    idx       = '0;
    cur       = '0;
    code_next = code_reg;
    ptr_next  = ptr_reg;
    for (int k = 0; k < NSTG; k++) begin
      idx_ext = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (idx_ext >= (PTR_W+1)'(NSTG)) idx_ext = idx_ext - (PTR_W+1)'(NSTG);
      idx    = idx_ext[PTR_W-1:0];
      at_lim = go_up ? (code_reg[idx] == CODE_W'(CODE_MAX)) : (code_reg[idx] == '0);
      if (!found && !at_lim) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    if (en && state_reg == UPDATE && !in_lock && found) begin
      cur = code_reg[sel];
      if (go_up)
        code_next[sel] = (cur > CODE_W'(CODE_MAX) - step) ? CODE_W'(CODE_MAX) : cur + step;
      else
        code_next[sel] = (cur < step) ? '0 : cur - step;
      ptr_next = (sel == PTR_W'(NSTG - 1)) ? '0 : sel + PTR_W'(1);
    end
  end

  always_ff @(posedge ref_clk or negedge rstb) begin
    if (!rstb) begin
      state_reg    <= IDLE;
      glob_en      <= 1'b0;
      locked       <= 1'b0;
      sat          <= 1'b0;
      meas_cnt     <= '0;
      cnt0_reg     <= '0;
      cnt1_reg     <= '0;
      win_cnt_reg  <= '0;
      err_reg      <= '0;
      ptr_reg      <= '0;
      lock_cnt_reg <= '0;
      lfsr_reg     <= 16'hACE1;
      con_perb     <= '0;
      for (int i = 0; i < NSTG; i++) begin
        code_reg[i]      <= INIT_C;
        delay_con_msb[i] <= code2therm(INIT_C[8:5]);
        delay_con_lsb[i] <= INIT_C[4:0];
      end
    end else begin
      for (int i = 0; i < NSTG; i++) begin
        code_reg[i]      <= code_next[i];
        delay_con_msb[i] <= code2therm(code_next[i][8:5]);
        delay_con_lsb[i] <= code_next[i][4:0];
      end
      ptr_reg <= ptr_next;

      if (dither_en) begin
        lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        con_perb <= perb_next;
      end else begin
        con_perb <= '0;
      end

      if (!en) begin
        state_reg    <= IDLE;
        glob_en      <= 1'b0;
        locked       <= 1'b0;
        lock_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= START;
            glob_en   <= 1'b1;
          end
          START: begin
            cnt0_reg    <= cnt_bin;
            win_cnt_reg <= '0;
            state_reg   <= MEAS;
          end
          MEAS: begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
            if (win_cnt_reg == WIN_W'(WIN_CYC - 2)) begin
              cnt1_reg  <= cnt_bin;
              state_reg <= CALC;
            end
          end
          CALC: begin
            meas_cnt  <= meas_diff;
            err_reg   <= $signed({1'b0, meas_diff}) - $signed({1'b0, target_cnt});
            state_reg <= UPDATE;
          end
          UPDATE: begin
            sat <= !in_lock && !found;
            if (in_lock) begin
              if (lock_cnt_reg < LCK_W'(LOCK_CNT)) lock_cnt_reg <= lock_cnt_reg + 1'b1;
              if (lock_cnt_reg >= LCK_W'(LOCK_CNT - 1)) locked <= 1'b1;
            end else begin
              lock_cnt_reg <= '0;
              locked       <= 1'b0;
            end
            state_reg <= START;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
